// File: rtl/fetch_resp_queue_pkg.sv
// Shared types and defaults for the fetch response queue: the entry layout and
// the classification of an incoming response beat.
package fetch_resp_queue_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_data_t;

   localparam int FQ_DATA_W  = $bits(fetch_data_t);
   localparam int FQ_DEPTH   = 4;
   localparam int FQ_MAX_OUT = 4;

   // What happens to a response beat in the current cycle.
   typedef enum logic [1:0] {
      RESP_NONE,
      RESP_WRITE,
      RESP_DROP,
      RESP_ERR
   } resp_act_e;

endpackage

// File: rtl/fq_ram.sv
// DEPTH x DATA_W storage for the fetch response queue: one synchronous write
// port, one asynchronous read port.
module fq_ram
   import fetch_resp_queue_pkg::*;
#(
   parameter int DATA_W = FQ_DATA_W,
   parameter int DEPTH  = FQ_DEPTH
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: the array has no reset; occupancy is tracked by the queue's count,
   // so stale contents are never presented as valid.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_resp_queue.sv
// Decoupling FIFO between instruction-bus responses and decode, with credit
// throttling of bus requests and discard of responses made stale by a flush.
module fetch_resp_queue
   import fetch_resp_queue_pkg::*;
#(
   parameter int DATA_W  = FQ_DATA_W,
   parameter int DEPTH   = FQ_DEPTH,
   parameter int MAX_OUT = FQ_MAX_OUT
) (
   input  logic                         clk,
   input  logic                         resetn,
   output logic                         req_credit,
   input  logic                         req_fire,
   input  logic                         resp_valid,
   input  logic [DATA_W-1:0]            resp_data,
   input  logic                         flush,
   output logic                         deq_valid,
   output logic [DATA_W-1:0]            deq_data,
   input  logic                         deq_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(MAX_OUT + 1);
   localparam int SW = ((CW > OW) ? CW : OW) + 1;

   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [OW-1:0] out_cnt, drop_cnt;
   logic [OW-1:0] out_nxt, drop_nxt, live;
   logic [CW-1:0] count_nxt;
   logic [SW-1:0] occ_sum, out_sum;
   logic [DATA_W-1:0] ram_rdata;
   resp_act_e     resp_act;
   logic          resp_dec, wr_en, rd_en, err_set;

   // Every live response already owns a slot, so the FIFO cannot overflow.
   assign live       = out_cnt - drop_cnt;
   assign occ_sum    = SW'(count) + SW'(live);
   assign req_credit = (occ_sum < SW'(DEPTH)) && (out_cnt < OW'(MAX_OUT));

   always_comb begin
      // NOTE: default first, so no path through the if-chain leaves resp_act
      // unassigned and no latch is inferred.
      resp_act = RESP_NONE;
      if (resp_valid) begin
         if (out_cnt == '0)                 resp_act = RESP_ERR;
         else if (drop_cnt != '0 || flush)  resp_act = RESP_DROP;
         else                               resp_act = RESP_WRITE;
      end
   end

   assign resp_dec  = (resp_act == RESP_WRITE) || (resp_act == RESP_DROP);
   assign wr_en     = (resp_act == RESP_WRITE);
   assign deq_valid = (count != '0);
   assign rd_en     = deq_valid && deq_ready && !flush;
   assign err_set   = (resp_act == RESP_ERR) || (req_fire && !req_credit);

   // An illegal request still counts, but never pushes out_cnt past MAX_OUT.
   assign out_sum = SW'(out_cnt) + SW'(req_fire) - SW'(resp_dec);
   assign out_nxt = (out_sum > SW'(MAX_OUT)) ? OW'(MAX_OUT) : OW'(out_sum);

   // On flush everything in flight becomes stale except the beat retiring now;
   // a request fired in the flush cycle belongs to the new stream.
   always_comb begin
      drop_nxt = drop_cnt;
      if (flush)                       drop_nxt = out_cnt - OW'(resp_dec);
      else if (resp_act == RESP_DROP)  drop_nxt = drop_cnt - OW'(1);
   end

   assign count_nxt = flush ? '0 : (count + CW'(wr_en) - CW'(rd_en));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         out_cnt  <= '0;
         drop_cnt <= '0;
         err      <= 1'b0;
      end else begin
         out_cnt  <= out_nxt;
         drop_cnt <= drop_nxt;
         count    <= count_nxt;
         err      <= err | err_set;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (flush)      rd_ptr <= wr_ptr;
         else if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   fq_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (resp_data),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   // Masking keeps the head at zero out of reset even though the array is not reset.
   assign deq_data = deq_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_fetch_resp_queue.sv
// Directed, table-driven bench for fetch_resp_queue at DEPTH=4, MAX_OUT=4.
module tb_fetch_resp_queue;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_credit;
   logic        req_fire;
   logic        resp_valid;
   logic [63:0] resp_data;
   logic        flush;
   logic        deq_valid;
   logic [63:0] deq_data;
   logic        deq_ready;
   logic [2:0]  count;
   logic        err;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic        rf;
      logic        rv;
      logic [63:0] rd;
      logic        fl;
      logic        dr;
      logic        e_credit;
      logic        e_valid;
      logic [63:0] e_data;
      int          e_count;
      logic        e_err;
   } vec_t;

   vec_t tbl[$];

   fetch_resp_queue #(.DATA_W(64), .DEPTH(4), .MAX_OUT(4)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req_credit (req_credit),
      .req_fire   (req_fire),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .flush      (flush),
      .deq_valid  (deq_valid),
      .deq_data   (deq_data),
      .deq_ready  (deq_ready),
      .count      (count),
      .err        (err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   function automatic vec_t mk(input logic rf, input logic rv, input logic [63:0] rd,
                               input logic fl, input logic dr, input logic ec,
                               input logic ev, input logic [63:0] ed, input int ecnt,
                               input logic ee);
      vec_t v;
      v.rf = rf; v.rv = rv; v.rd = rd; v.fl = fl; v.dr = dr;
      v.e_credit = ec; v.e_valid = ev; v.e_data = ed; v.e_count = ecnt; v.e_err = ee;
      return v;
   endfunction

   task automatic cmp(input string name, input string field,
                      input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %0h, expected %0h", name, field, act, exp);
      end
   endtask

   task automatic check_outputs(input string name, input logic ec, input logic ev,
                                input logic [63:0] ed, input int ecnt, input logic ee,
                                input logic chk_data);
      cmp(name, "req_credit", 64'(req_credit), 64'(ec));
      cmp(name, "deq_valid",  64'(deq_valid),  64'(ev));
      cmp(name, "count",      64'(count),      64'(ecnt));
      cmp(name, "err",        64'(err),        64'(ee));
      if (chk_data) cmp(name, "deq_data", deq_data, ed);
   endtask

   // Drive one cycle of inputs, then check the state right after the clock edge.
   task automatic run_vec(input string name, input vec_t v);
      req_fire   = v.rf;
      resp_valid = v.rv;
      resp_data  = v.rd;
      flush      = v.fl;
      deq_ready  = v.dr;
      @(posedge clk);
      #1;
      check_outputs(name, v.e_credit, v.e_valid, v.e_data, v.e_count, v.e_err, v.e_valid);
   endtask

   initial begin
      resetn = 1'b0; req_fire = 1'b0; resp_valid = 1'b0; resp_data = '0;
      flush = 1'b0; deq_ready = 1'b0;

      //        rf rv data    fl dr  credit valid data    cnt err
      // basic flow: four requests, responses A..D drained as they arrive
      tbl.push_back(mk(1, 0, 64'h0,  0, 1,  1, 0, 64'h0,  0, 0));
      tbl.push_back(mk(1, 0, 64'h0,  0, 1,  1, 0, 64'h0,  0, 0));
      tbl.push_back(mk(1, 0, 64'h0,  0, 1,  1, 0, 64'h0,  0, 0));
      tbl.push_back(mk(1, 0, 64'h0,  0, 1,  0, 0, 64'h0,  0, 0));
      tbl.push_back(mk(0, 1, 64'hA,  0, 1,  0, 1, 64'hA,  1, 0));
      tbl.push_back(mk(0, 1, 64'hB,  0, 1,  1, 1, 64'hB,  1, 0));
      tbl.push_back(mk(0, 1, 64'hC,  0, 1,  1, 1, 64'hC,  1, 0));
      tbl.push_back(mk(0, 1, 64'hD,  0, 1,  1, 1, 64'hD,  1, 0));
      tbl.push_back(mk(0, 0, 64'h0,  0, 1,  1, 0, 64'h0,  0, 0));
      // back-pressure: fill to DEPTH with decode stalled, then drain
      tbl.push_back(mk(1, 0, 64'h0,  0, 0,  1, 0, 64'h0,  0, 0));
      tbl.push_back(mk(1, 0, 64'h0,  0, 0,  1, 0, 64'h0,  0, 0));
      tbl.push_back(mk(1, 0, 64'h0,  0, 0,  1, 0, 64'h0,  0, 0));
      tbl.push_back(mk(1, 0, 64'h0,  0, 0,  0, 0, 64'h0,  0, 0));
      tbl.push_back(mk(0, 1, 64'h11, 0, 0,  0, 1, 64'h11, 1, 0));
      tbl.push_back(mk(0, 1, 64'h12, 0, 0,  0, 1, 64'h11, 2, 0));
      tbl.push_back(mk(0, 1, 64'h13, 0, 0,  0, 1, 64'h11, 3, 0));
      tbl.push_back(mk(0, 1, 64'h14, 0, 0,  0, 1, 64'h11, 4, 0));
      tbl.push_back(mk(0, 0, 64'h0,  0, 1,  1, 1, 64'h12, 3, 0));
      tbl.push_back(mk(0, 0, 64'h0,  0, 1,  1, 1, 64'h13, 2, 0));
      tbl.push_back(mk(0, 0, 64'h0,  0, 1,  1, 1, 64'h14, 1, 0));
      tbl.push_back(mk(0, 0, 64'h0,  0, 1,  1, 0, 64'h0,  0, 0));

      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset", 1, 0, 64'h0, 0, 0, 1);
      resetn = 1'b1;

      foreach (tbl[i]) run_vec($sformatf("tbl%0d", i), tbl[i]);

      // stale drop: three in flight, flush, one post-flush request
      run_vec("stale_rq0",   mk(1, 0, 64'h0,  0, 0,  1, 0, 64'h0,  0, 0));
      run_vec("stale_rq1",   mk(1, 0, 64'h0,  0, 0,  1, 0, 64'h0,  0, 0));
      run_vec("stale_rq2",   mk(1, 0, 64'h0,  0, 0,  1, 0, 64'h0,  0, 0));
      run_vec("stale_flush", mk(0, 0, 64'h0,  1, 0,  1, 0, 64'h0,  0, 0));
      run_vec("stale_newrq", mk(1, 0, 64'h0,  0, 0,  0, 0, 64'h0,  0, 0));
      run_vec("stale_drop0", mk(0, 1, 64'h51, 0, 0,  1, 0, 64'h0,  0, 0));
      run_vec("stale_drop1", mk(0, 1, 64'h52, 0, 0,  1, 0, 64'h0,  0, 0));
      run_vec("stale_drop2", mk(0, 1, 64'h53, 0, 0,  1, 0, 64'h0,  0, 0));
      run_vec("stale_keep",  mk(0, 1, 64'h54, 0, 0,  1, 1, 64'h54, 1, 0));
      run_vec("stale_deq",   mk(0, 0, 64'h0,  0, 1,  1, 0, 64'h0,  0, 0));

      // flush + response + request in one cycle, with one entry queued and out_cnt=2
      run_vec("coll_rq0",    mk(1, 0, 64'h0,  0, 0,  1, 0, 64'h0,  0, 0));
      run_vec("coll_rq1",    mk(1, 0, 64'h0,  0, 0,  1, 0, 64'h0,  0, 0));
      run_vec("coll_rq2",    mk(1, 0, 64'h0,  0, 0,  1, 0, 64'h0,  0, 0));
      run_vec("coll_fill",   mk(0, 1, 64'h61, 0, 0,  1, 1, 64'h61, 1, 0));
      run_vec("coll_flush",  mk(1, 1, 64'h62, 1, 1,  1, 0, 64'h0,  0, 0));
      run_vec("coll_drop",   mk(0, 1, 64'h63, 0, 0,  1, 0, 64'h0,  0, 0));
      run_vec("coll_keep",   mk(0, 1, 64'h64, 0, 0,  1, 1, 64'h64, 1, 0));
      run_vec("coll_deq",    mk(0, 0, 64'h0,  0, 1,  1, 0, 64'h0,  0, 0));

      // wrap-around: ten enqueue/dequeue pairs walk both pointers past DEPTH
      for (int i = 0; i < 10; i++) begin
         run_vec($sformatf("wrap_rq%0d", i), mk(1, 0, 64'h0, 0, 1, 1, 0, 64'h0, 0, 0));
         run_vec($sformatf("wrap_rsp%0d", i),
                 mk(0, 1, 64'h100 + 64'(i), 0, 0, 1, 1, 64'h100 + 64'(i), 1, 0));
      end
      run_vec("wrap_deq",    mk(0, 0, 64'h0,  0, 1,  1, 0, 64'h0,  0, 0));

      // unsolicited response sets the sticky error
      run_vec("err_resp",    mk(0, 1, 64'h77, 0, 0,  1, 0, 64'h0,  0, 1));
      run_vec("err_sticky",  mk(0, 0, 64'h0,  0, 0,  1, 0, 64'h0,  0, 1));

      // reset mid-stream with two entries queued
      run_vec("rst_rq0",     mk(1, 0, 64'h0,  0, 0,  1, 0, 64'h0,  0, 1));
      run_vec("rst_rq1",     mk(1, 0, 64'h0,  0, 0,  1, 0, 64'h0,  0, 1));
      run_vec("rst_fill0",   mk(0, 1, 64'h81, 0, 0,  1, 1, 64'h81, 1, 1));
      run_vec("rst_fill1",   mk(0, 1, 64'h82, 0, 0,  1, 1, 64'h81, 2, 1));
      req_fire = 1'b0; resp_valid = 1'b0; flush = 1'b0; deq_ready = 1'b0;
      resetn = 1'b0;
      #1;
      check_outputs("rst_async", 1, 0, 64'h0, 0, 0, 1);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      run_vec("rst_idle",    mk(0, 0, 64'h0,  0, 0,  1, 0, 64'h0,  0, 0));
      run_vec("rst_rq",      mk(1, 0, 64'h0,  0, 0,  1, 0, 64'h0,  0, 0));
      run_vec("rst_resp",    mk(0, 1, 64'h91, 0, 0,  1, 1, 64'h91, 1, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
